// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (signed/unsigned) with start/busy/done handshake
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs, prem, prem_n, dvd_n, a_mag, b_mag;
  logic [WIDTH:0] prem_s, diff;
  logic qneg, rneg, a_neg, b_neg, last, zero;
  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
    zero = divisor == '0;
    prem_s = {prem, dvd[WIDTH-1]};
    diff = prem_s - {1'b0, dvs};
    prem_n = diff[WIDTH] ? prem_s[WIDTH-1:0] : diff[WIDTH-1:0];
    dvd_n = {dvd[WIDTH-2:0], ~diff[WIDTH]};
    last = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE ? (start ? (zero ? DONE : CALC) : IDLE) :
              state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  assign busy = state == CALC;
  assign done = state == DONE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      prem <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      dvd <= a_mag;
      dvs <= b_mag;
      prem <= '0;
      qneg <= a_neg ^ b_neg;
      rneg <= a_neg;
      div_by_zero <= zero;
      if (zero) begin
        quotient <= '1;
        remainder <= dividend;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      dvd <= dvd_n;
      prem <= prem_n;
      if (last) begin
        quotient <= qneg ? -dvd_n : dvd_n;
        remainder <= rneg ? -prem_n : prem_n;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven scoreboard bench for div_unit
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, quotient, remainder;
  logic busy, done, div_by_zero;
  int vec = 0, mis = 0;
  typedef struct {
    logic s;
    logic [31:0] a, b, q, r;
    logic z;
  } vec_t;
  vec_t tbl[13];
  vec_t sb[$];
  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic quiet(input int k);
    int d = 0;
    repeat (k) begin
      @(posedge clk); #1;
      if (done) d++;
    end
    chk("no_extra_done", d, 0);
  endtask
  task automatic run_op(input vec_t v, input bit poke);
    int n = 0, nb = 0;
    vec_t e;
    sb.push_back(v);
    @(posedge clk); #1;
    is_signed = v.s; dividend = v.a; divisor = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (poke && n == 10) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, v.b == 0 ? 1 : 33);
    chk("busy_cycles", nb, v.b == 0 ? 0 : 32);
    chk("busy_at_done", {31'b0, busy}, 0);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
    end else chk("done_seen", {31'b0, done}, 1);
    quiet(poke ? 40 : 1);
  endtask
  task automatic reset_mid();
    int n;
    @(posedge clk); #1;
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", {31'b0, div_by_zero}, 0);
    quiet(40);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1]  = '{1'b1, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{1'b1, 32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0};
    tbl[3]  = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
    tbl[4]  = '{1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
    tbl[5]  = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    tbl[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    tbl[7]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    tbl[8]  = '{1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    tbl[9]  = '{1'b1, -32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE, 1'b0};
    tbl[10] = '{1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    tbl[11] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0};
    tbl[12] = '{1'b0, 32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", {31'b0, div_by_zero}, 0);
    foreach (tbl[i]) run_op(tbl[i], 1'b0);
    run_op(tbl[0], 1'b1);
    reset_mid();
    run_op(tbl[5], 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
